// File: rtl/pcecd_pkg.sv
// Shared definitions for the PCE CD SCSI-style bus: phase codes, bus bit
// masks, error codes and the initiator state encoding.
package pcecd_pkg;

  localparam int BYTE_W = 8;

  // Bus phases as {msg, cd, io}; meaningful only while bsy is high.
  localparam logic [2:0] PHASE_DATA_IN = 3'b001;
  localparam logic [2:0] PHASE_COMMAND = 3'b010;
  localparam logic [2:0] PHASE_STATUS  = 3'b011;
  localparam logic [2:0] PHASE_MSG_IN  = 3'b111;

  // Bit masks for a packed {bsy, req, msg, cd, io} status vector.
  localparam logic [4:0] MASK_BUSY = 5'b10000;
  localparam logic [4:0] MASK_REQ  = 5'b01000;
  localparam logic [4:0] MASK_MSG  = 5'b00100;
  localparam logic [4:0] MASK_CD   = 5'b00010;
  localparam logic [4:0] MASK_IO   = 5'b00001;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_SEL_TIMEOUT = 3'd1,
    ERR_CMD_OVERRUN = 3'd2,
    ERR_BUS_FREE    = 3'd3,
    ERR_ABORTED     = 3'd4
  } err_t;

  // Initiator state encoding.
  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_SELECT     = 4'd1;
  localparam logic [3:0] ST_PHASE_WAIT = 4'd2;
  localparam logic [3:0] ST_CMD_SETUP  = 4'd3;
  localparam logic [3:0] ST_ACK_HOLD   = 4'd4;
  localparam logic [3:0] ST_RESET      = 4'd5;
  localparam logic [3:0] ST_FINISH     = 4'd6;

endpackage

// File: rtl/pcecd_scsi_initiator_if.sv
// Initiator/target bus bundle. The master modport is the initiator side.
interface pcecd_scsi_initiator_if;
  import pcecd_pkg::*;

  logic              bsy;
  logic              req;
  logic              msg;
  logic              cd;
  logic              io;
  logic [BYTE_W-1:0] db_in;
  logic              sel;
  logic              ack;
  logic              rst;
  logic [BYTE_W-1:0] db_out;

  modport master (
    input  bsy, req, msg, cd, io, db_in,
    output sel, ack, rst, db_out
  );

  modport slave (
    output bsy, req, msg, cd, io, db_in,
    input  sel, ack, rst, db_out
  );

endinterface

// File: rtl/pcecd_cmd_buf.sv
// Command byte register file: synchronous write, combinational read.
module pcecd_cmd_buf
  import pcecd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // Store one command byte per write strobe; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pcecd_scsi_initiator.sv
// Initiator end of the PCE CD bus: selection, command out, data in,
// status, message, bus free, with timeout, overrun and abort handling.
module pcecd_scsi_initiator
  import pcecd_pkg::*;
#(
  parameter int SEL_TIMEOUT = 1024,
  parameter int RST_CYCLES  = 16,
  parameter int CMD_MAX     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pcecd_scsi_initiator_if.master bus,
  input  logic                  cmd_we,
  input  logic [3:0]            cmd_addr,
  input  logic [7:0]            cmd_data,
  input  logic [4:0]            cmd_len,
  input  logic                  start,
  input  logic                  abort,
  output logic                  data_valid,
  output logic [7:0]            data_byte,
  output logic [7:0]            status_byte,
  output logic [7:0]            message_byte,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            error
);

  localparam int AW = $clog2(CMD_MAX);

  logic [3:0]  state_reg;
  logic [15:0] cnt_reg;
  logic [4:0]  idx_reg;
  logic [4:0]  len_reg;
  logic        sel_reg, ack_reg, rst_reg;
  logic [7:0]  db_out_reg;
  logic        data_valid_reg;
  logic [7:0]  data_byte_reg, status_reg, message_reg;
  logic        busy_reg, done_reg;
  err_t        error_reg;
  logic        msg_seen_reg;
  logic        cmd_phase_reg;

  logic [2:0]  phase;
  logic        buf_we;
  logic [7:0]  buf_rdata;

  assign phase = {bus.msg, bus.cd, bus.io};

  // A write coinciding with start, or during a transaction, is dropped.
  assign buf_we = cmd_we && !busy_reg && !start;

  pcecd_cmd_buf #(.DEPTH(CMD_MAX)) u_cmd_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cmd_addr[AW-1:0]),
    .wdata (cmd_data),
    .raddr (idx_reg[AW-1:0]),
    .rdata (buf_rdata)
  );

  // Transaction sequencer; abort outranks every other event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      len_reg        <= '0;
      sel_reg        <= 1'b0;
      ack_reg        <= 1'b0;
      rst_reg        <= 1'b0;
      db_out_reg     <= '0;
      data_valid_reg <= 1'b0;
      data_byte_reg  <= '0;
      status_reg     <= '0;
      message_reg    <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= ERR_NONE;
      msg_seen_reg   <= 1'b0;
      cmd_phase_reg  <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      if (abort && state_reg != ST_IDLE) begin
        sel_reg   <= 1'b0;
        ack_reg   <= 1'b0;
        rst_reg   <= 1'b1;
        cnt_reg   <= '0;
        error_reg <= ERR_ABORTED;
        state_reg <= ST_RESET;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              error_reg    <= ERR_NONE;
              idx_reg      <= '0;
              len_reg      <= cmd_len;
              busy_reg     <= 1'b1;
              msg_seen_reg <= 1'b0;
              cnt_reg      <= '0;
              sel_reg      <= 1'b1;
              state_reg    <= ST_SELECT;
            end
          end
          ST_SELECT: begin
            if (bus.bsy) begin
              sel_reg   <= 1'b0;
              state_reg <= ST_PHASE_WAIT;
            end else if (cnt_reg == 16'(SEL_TIMEOUT - 1)) begin
              sel_reg   <= 1'b0;
              error_reg <= ERR_SEL_TIMEOUT;
              state_reg <= ST_FINISH;
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end
          ST_PHASE_WAIT: begin
            if (!bus.bsy) begin
              // Bus free is the normal ending only after the message byte.
              if (!msg_seen_reg) error_reg <= ERR_BUS_FREE;
              state_reg <= ST_FINISH;
            end else if (bus.req && !msg_seen_reg) begin
              cmd_phase_reg <= 1'b0;
              case (phase)
                PHASE_COMMAND: begin
                  cmd_phase_reg <= 1'b1;
                  if (idx_reg < len_reg) begin
                    db_out_reg <= buf_rdata;
                  end else begin
                    db_out_reg <= 8'h00;
                    error_reg  <= ERR_CMD_OVERRUN;
                  end
                  state_reg <= ST_CMD_SETUP;
                end
                PHASE_DATA_IN: begin
                  data_byte_reg  <= bus.db_in;
                  data_valid_reg <= 1'b1;
                  ack_reg        <= 1'b1;
                  state_reg      <= ST_ACK_HOLD;
                end
                PHASE_STATUS: begin
                  status_reg <= bus.db_in;
                  ack_reg    <= 1'b1;
                  state_reg  <= ST_ACK_HOLD;
                end
                PHASE_MSG_IN: begin
                  message_reg  <= bus.db_in;
                  msg_seen_reg <= 1'b1;
                  ack_reg      <= 1'b1;
                  state_reg    <= ST_ACK_HOLD;
                end
                default: begin
                  error_reg <= ERR_BUS_FREE;
                  state_reg <= ST_FINISH;
                end
              endcase
            end
          end
          ST_CMD_SETUP: begin
            // db_out has had one full cycle to settle before ack.
            ack_reg   <= 1'b1;
            state_reg <= ST_ACK_HOLD;
          end
          ST_ACK_HOLD: begin
            if (!bus.req) begin
              ack_reg <= 1'b0;
              if (cmd_phase_reg && idx_reg != 5'h1f) idx_reg <= idx_reg + 5'd1;
              state_reg <= ST_PHASE_WAIT;
            end
          end
          ST_RESET: begin
            if (cnt_reg == 16'(RST_CYCLES - 1)) begin
              rst_reg   <= 1'b0;
              state_reg <= ST_FINISH;
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end
          ST_FINISH: begin
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            db_out_reg <= 8'h00;
            sel_reg    <= 1'b0;
            ack_reg    <= 1'b0;
            state_reg  <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sel      = sel_reg;
  assign bus.ack      = ack_reg;
  assign bus.rst      = rst_reg;
  assign bus.db_out   = db_out_reg;
  assign data_valid   = data_valid_reg;
  assign data_byte    = data_byte_reg;
  assign status_byte  = status_reg;
  assign message_byte = message_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign error        = error_reg;

endmodule

// File: tb/tb_pcecd_scsi_initiator.sv
// Directed and randomized checks of the initiator against a target model.
module tb_pcecd_scsi_initiator;
  import pcecd_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_we;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [4:0] cmd_len;
  logic       start;
  logic       abort;
  logic       data_valid;
  logic [7:0] data_byte;
  logic [7:0] status_byte;
  logic [7:0] message_byte;
  logic       busy;
  logic       done;
  logic [2:0] error;

  pcecd_scsi_initiator_if bus ();

  pcecd_scsi_initiator dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .cmd_we       (cmd_we),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_len      (cmd_len),
    .start        (start),
    .abort        (abort),
    .data_valid   (data_valid),
    .data_byte    (data_byte),
    .status_byte  (status_byte),
    .message_byte (message_byte),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Bus monitor: done pulses, data-in stream, rst width, ack-before-req.
  int         done_cnt = 0;
  logic [2:0] done_err = 3'd0;
  int         rst_cnt  = 0;
  int         viol     = 0;
  logic       ack_prev = 1'b0;
  logic [7:0] dv_q [$];

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_err <= error;
    end
    if (data_valid) dv_q.push_back(data_byte);
    if (bus.rst) rst_cnt <= rst_cnt + 1;
    if (bus.ack && !ack_prev && !bus.req) viol <= viol + 1;
    ack_prev <= bus.ack;
  end

  logic [7:0] tb_mem  [16];
  logic [7:0] tb_data [8];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check("done_pulse", 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic do_start(input int len);
    for (int i = 0; i < len; i++) begin
      cmd_we = 1'b1; cmd_addr = 4'(i); cmd_data = tb_mem[i];
      tick();
    end
    // Write on the start cycle must be ignored.
    cmd_len = 5'(len); start = 1'b1;
    cmd_we = 1'b1; cmd_addr = 4'd0; cmd_data = ~tb_mem[0];
    tick();
    start = 1'b0; cmd_we = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic tgt_select();
    int n = 0;
    while (!bus.sel && n < 16) begin tick(); n++; end
    check("sel_rise", 32'(bus.sel), 32'd1);
    bus.bsy = 1'b1;
    n = 0;
    tick();
    while (bus.sel && n < 16) begin tick(); n++; end
    check("sel_drop", 32'(bus.sel), 32'd0);
  endtask

  task automatic tgt_byte(input logic [2:0] ph, input logic [7:0] din, output logic [7:0] dout);
    int n = 0;
    repeat ($urandom_range(0, 2)) tick();
    {bus.msg, bus.cd, bus.io} = ph;
    bus.db_in = din;
    bus.req = 1'b1;
    tick();
    while (!bus.ack && n < 64) begin tick(); n++; end
    check("ack_rise", 32'(bus.ack), 32'd1);
    dout = bus.db_out;
    bus.req = 1'b0;
    n = 0;
    tick();
    while (bus.ack && n < 64) begin tick(); n++; end
    check("ack_fall", 32'(bus.ack), 32'd0);
  endtask

  // Full transaction; expectations come from the buffer image and length.
  task automatic run_txn(input int len, input int ncmd, input int ndata,
                         input logic [7:0] st, input logic [7:0] mg);
    logic [7:0] got;
    int d0, q0;
    do_start(len);
    tgt_select();
    for (int i = 0; i < ncmd; i++) begin
      tgt_byte(PHASE_COMMAND, 8'($urandom), got);
      check($sformatf("cmd_byte%0d", i), 32'(got), (i < len) ? 32'(tb_mem[i]) : 32'd0);
    end
    q0 = dv_q.size();
    for (int i = 0; i < ndata; i++) tgt_byte(PHASE_DATA_IN, tb_data[i], got);
    tgt_byte(PHASE_STATUS, st, got);
    tgt_byte(PHASE_MSG_IN, mg, got);
    d0 = done_cnt;
    bus.bsy = 1'b0;
    wait_done(d0, 64);
    check("status_byte", 32'(status_byte), 32'(st));
    check("message_byte", 32'(message_byte), 32'(mg));
    check("txn_error", 32'(done_err), (ncmd > len) ? 32'd2 : 32'd0);
    check("dv_count", 32'(dv_q.size() - q0), 32'(ndata));
    for (int i = 0; i < ndata && q0 + i < dv_q.size(); i++)
      check($sformatf("dv_byte%0d", i), 32'(dv_q[q0 + i]), 32'(tb_data[i]));
    check("busy_at_end", 32'(busy), 32'd0);
    check("db_out_at_end", 32'(bus.db_out), 32'd0);
  endtask

  initial begin
    logic [7:0] got;
    int n, d0, r0, len, ncmd, nd;
    reset_n = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_len = '0;
    start = 1'b0; abort = 1'b0;
    bus.bsy = 1'b0; bus.req = 1'b0; bus.msg = 1'b0; bus.cd = 1'b0; bus.io = 1'b0;
    bus.db_in = '0;
    repeat (3) tick();
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rst", 32'(bus.rst), 32'd0);
    check("rst_outs", {22'd0, busy, done, data_valid, error, bus.db_out == 8'd0}, 32'd1);
    reset_n = 1'b1;
    tick();

    // Selection timeout with no target.
    for (int i = 0; i < 16; i++) tb_mem[i] = 8'($urandom);
    do_start(2);
    d0 = done_cnt; n = 0;
    while (bus.sel && n < 2000) begin n++; tick(); end
    check("sel_high_cycles", 32'(n), 32'd1024);
    wait_done(d0, 8);
    check("timeout_error", 32'(done_err), 32'd1);
    $display("txn select_timeout sel_cycles=%0d err=%0d", n, done_err);

    // Canonical 6-byte command, no data.
    tb_mem[0] = 8'h08; tb_mem[1] = 8'h00; tb_mem[2] = 8'h00;
    tb_mem[3] = 8'h10; tb_mem[4] = 8'h01; tb_mem[5] = 8'h00;
    run_txn(6, 6, 0, 8'h00, 8'h00);
    $display("txn read6 status=%02h msg=%02h err=%0d", status_byte, message_byte, done_err);

    // Same command with four data-in bytes.
    tb_data[0] = 8'hDE; tb_data[1] = 8'hAD; tb_data[2] = 8'hBE; tb_data[3] = 8'hEF;
    run_txn(6, 6, 4, 8'h00, 8'h00);
    $display("txn read6_data4 err=%0d", done_err);

    // Target asks for a seventh command byte.
    run_txn(6, 7, 0, 8'h02, 8'h00);
    $display("txn overrun err=%0d", done_err);

    // Randomized transactions, some with overrun.
    for (int t = 0; t < 6; t++) begin
      len  = $urandom_range(1, 16);
      ncmd = len + (($urandom_range(0, 3) == 0) ? 1 : 0);
      nd   = $urandom_range(0, 5);
      for (int i = 0; i < 16; i++) tb_mem[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) tb_data[i] = 8'($urandom);
      run_txn(len, ncmd, nd, 8'($urandom), 8'($urandom));
      $display("txn random%0d len=%0d ncmd=%0d ndata=%0d err=%0d", t, len, ncmd, nd, done_err);
    end

    // Target drops bsy in the middle of COMMAND.
    do_start(6);
    tgt_select();
    tgt_byte(PHASE_COMMAND, 8'h00, got);
    tgt_byte(PHASE_COMMAND, 8'h00, got);
    d0 = done_cnt;
    bus.bsy = 1'b0;
    wait_done(d0, 16);
    check("busfree_error", 32'(done_err), 32'd3);
    check("busfree_sel_ack", {30'd0, bus.sel, bus.ack}, 32'd0);
    $display("txn bus_free err=%0d", done_err);

    // Abort while a data-in byte is being acknowledged.
    do_start(1);
    tgt_select();
    tgt_byte(PHASE_COMMAND, 8'h00, got);
    {bus.msg, bus.cd, bus.io} = PHASE_DATA_IN; bus.db_in = 8'h5A; bus.req = 1'b1;
    n = 0;
    tick();
    while (!bus.ack && n < 16) begin tick(); n++; end
    d0 = done_cnt; r0 = rst_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0; bus.req = 1'b0; bus.bsy = 1'b0;
    wait_done(d0, 64);
    check("abort_rst_cycles", 32'(rst_cnt - r0), 32'd16);
    check("abort_error", 32'(done_err), 32'd4);
    check("abort_rst_low", 32'(bus.rst), 32'd0);
    $display("txn abort rst_cycles=%0d err=%0d", rst_cnt - r0, done_err);
    for (int i = 0; i < 16; i++) tb_mem[i] = 8'($urandom);
    tb_data[0] = 8'h11; tb_data[1] = 8'h22;
    run_txn(5, 5, 2, 8'h00, 8'h00);
    $display("txn after_abort err=%0d", done_err);

    // Asynchronous reset with ack high: outputs clear at once, no done.
    do_start(3);
    tgt_select();
    {bus.msg, bus.cd, bus.io} = PHASE_COMMAND; bus.req = 1'b1;
    n = 0;
    tick();
    while (!bus.ack && n < 16) begin tick(); n++; end
    check("pre_reset_ack", 32'(bus.ack), 32'd1);
    d0 = done_cnt;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outs", {27'd0, bus.sel, bus.ack, bus.rst, busy, bus.db_out == 8'd0}, 32'd1);
    bus.req = 1'b0; bus.bsy = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("async_reset_no_done", 32'(done_cnt), 32'(d0));
    $display("txn async_reset done_cnt=%0d", done_cnt);

    check("ack_before_req", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pcecd_scsi_initiator.md
Name: pcecd_scsi_initiator

Overview:
- Initiator end of the PCE CD SCSI-style bus. The CD interface block acts as the target on the other end; it drives BSY/REQ/MSG/CD/IO and waits on SEL/ACK/RST.
- Runs one full transaction: selection, command bytes out, optional data-in bytes, status byte, message byte, bus free.
- Used as the bench/host-side driver of the CD target and as the basis for a system-card command engine.

Parameters:
- SEL_TIMEOUT, 1024, cycles SEL may stay asserted without BSY before a selection error.
- RST_CYCLES, 16, cycles RST is held after abort.
- CMD_MAX, 16, command buffer depth. Power of two; cmd_len must not exceed it.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_we  in  1  write strobe for the command buffer (ignored while busy)
- cmd_addr  in  4  command buffer index
- cmd_data  in  8  command byte
- cmd_len  in  5  number of command bytes, 1..CMD_MAX; sampled on start
- start  in  1  one-cycle pulse that begins a transaction (ignored while busy)
- abort  in  1  one-cycle pulse that forces a bus reset
- bsy, req, msg, cd, io  in  1 each  target-driven bus signals, synchronous to clk
- db_in  in  8  target-to-initiator data bus
- sel  out  1  select
- ack  out  1  acknowledge
- rst  out  1  bus reset
- db_out  out  8  initiator-to-target data bus
- data_valid  out  1  one-cycle pulse per data-in byte
- data_byte  out  8  captured data-in byte
- status_byte  out  8  captured status byte
- message_byte  out  8  captured message byte
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at the end of a transaction
- error  out  3  error code: 0 none, 1 selection timeout, 2 command overrun, 3 unexpected bus free, 4 aborted

Behaviour:
- Reset values: all outputs 0, state IDLE, byte index 0, command buffer contents undefined.
- Phase decode {msg,cd,io}, valid only while bsy=1: 010 COMMAND, 001 DATA_IN, 011 STATUS, 111 MSG_IN. Any other code is a protocol error and is treated as code 3.
- IDLE:
  - start clears error and byte index, latches cmd_len, sets busy.
  - Next cycle assert sel and enter SELECT.
- SELECT:
  - bsy=1 → drop sel next cycle, go to PHASE_WAIT.
  - Counter reaches SEL_TIMEOUT → drop sel, error=1, go to FINISH.
- PHASE_WAIT: wait for req=1, then branch on the decoded phase.
  - bsy=0 before a message byte has been received → error=3, go to FINISH.
- COMMAND:
  - Drive db_out=buf[idx]; assert ack one cycle later (one-cycle data setup).
  - If idx ≥ cmd_len, drive 0x00 instead and set error=2. The transfer continues.
- DATA_IN: on the req=1 sample, capture db_in into data_byte, pulse data_valid, assert ack next cycle.
- STATUS: capture db_in into status_byte, assert ack.
- MSG_IN: capture db_in into message_byte, set the msg_seen flag, assert ack.
- ACK_HOLD:
  - Keep ack=1 until req=0 is sampled.
  - ack falls the cycle after req=0; in COMMAND, idx increments on that same cycle.
  - Return to PHASE_WAIT. A full byte takes a minimum of 4 cycles.
- After MSG_IN completes: wait for bsy=0, then FINISH with error unchanged.
- FINISH: one-cycle done pulse, busy=0, db_out=0, back to IDLE.
- abort (any state except IDLE):
  - Drop sel/ack, assert rst for RST_CYCLES cycles, error=4, then FINISH.
  - abort takes priority over every other event in the same cycle.
- Simultaneous events:
  - start together with cmd_we: the write is ignored.
  - req already high on entry to PHASE_WAIT is handled immediately; no edge detection.
- Asynchronous reset mid-transaction: all outputs go to 0 immediately, including sel/ack/rst. No done pulse is generated.
- idx is 5 bits and never wraps; buffer reads use idx[3:0] only when idx < cmd_len.

Decomposition:
- Shared package pcecd_pkg holds:
  - phase encodings (PHASE_COMMAND etc. as {msg,cd,io} 3-bit constants, shared with the target block)
  - bit masks BUSY/REQ/MSG/CD/IO
  - error code enum
  - state enum for this block
- Sub-module pcecd_cmd_buf: CMD_MAX×8 register file with synchronous write and combinational read.
- The FSM, timeout counter and reset counter stay in the top level.

Test Plan:
- Select timeout: start with bsy held 0 → sel high for exactly SEL_TIMEOUT cycles, then error=1 and done pulses.
- 6-byte command 0x08,0x00,0x00,0x10,0x01,0x00 against a responsive target model, then status 0x00 and message 0x00 → target receives the bytes in order; status_byte=0x00, message_byte=0x00, error=0, one done pulse.
- Data-in of 4 bytes 0xDE,0xAD,0xBE,0xEF between command and status → four data_valid pulses carrying those values in order; ack never rises before req.
- Target requests 7 command bytes when cmd_len=6 → the 7th byte on db_out is 0x00; error=2 at done.
- Target drops bsy during COMMAND → error=3, done pulses, sel=ack=0.
- abort during DATA_IN → rst high for 16 cycles, error=4, done pulses. A second start after this runs cleanly.
